// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit: one single-beat Wishbone-style access per request
// Loads are aligned/extended here and written straight into the register file in the done cycle.
module load_store_unit #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  output logic        busy,
  output logic        done,
  output logic        fault,
  output logic        bus_cyc,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [31:0] bus_adr,
  output logic [3:0]  bus_sel,
  output logic [31:0] bus_dat_o,
  input  logic [31:0] bus_dat_i,
  input  logic        bus_ack,
  output logic        rf_wr,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_rd_d
);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t      state_q, state_d;
  logic        is_store_q, is_store_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] store_data_q, store_data_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] cnt_q, cnt_d;
  logic        fault_q, fault_d;
  logic        rf_wr_q, rf_wr_d;
  logic [31:0] rf_data_q, rf_data_d;

  logic        illegal, misaligned, in_bus;
  logic [3:0]  lane_sel;
  logic [31:0] lane_dat;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;

  // Request checks look at the raw inputs because they are evaluated in the latching cycle.
  assign illegal    = is_store ? (funct3 > 3'b010)
                               : (funct3 == 3'b011 || funct3[2:1] == 2'b11);
  assign misaligned = (funct3[1:0] == 2'b01 && addr[0]) ||
                      (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);

  always_comb begin
    lane_sel = 4'b1111;
    lane_dat = store_data_q;
    case (funct3_q[1:0])
      2'b00: begin
        lane_sel = 4'b0001 << addr_q[1:0];
        lane_dat = {4{store_data_q[7:0]}};
      end
      2'b01: begin
        lane_sel = addr_q[1] ? 4'b1100 : 4'b0011;
        lane_dat = {2{store_data_q[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = bus_dat_i[7:0];
    case (addr_q[1:0])
      2'b01:   ld_byte = bus_dat_i[15:8];
      2'b10:   ld_byte = bus_dat_i[23:16];
      2'b11:   ld_byte = bus_dat_i[31:24];
      default: ;
    endcase
    ld_half = addr_q[1] ? bus_dat_i[31:16] : bus_dat_i[15:0];
    case (funct3_q)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'h0, ld_byte};
      3'b101:  ld_val = {16'h0, ld_half};
      default: ld_val = bus_dat_i;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    is_store_d   = is_store_q;
    funct3_d     = funct3_q;
    addr_d       = addr_q;
    store_data_d = store_data_q;
    rd_d         = rd_q;
    cnt_d        = cnt_q;
    fault_d      = fault_q;
    rf_wr_d      = 1'b0;
    rf_data_d    = rf_data_q;
    case (state_q)
      IDLE: begin
        cnt_d = 32'h0;
        if (start) begin
          is_store_d   = is_store;
          funct3_d     = funct3;
          addr_d       = addr;
          store_data_d = store_data;
          rd_d         = rd_in;
          fault_d      = illegal | misaligned;
          state_d      = (illegal | misaligned) ? RESP : BUS;
        end
      end
      BUS: begin
        if (bus_ack) begin
          state_d   = RESP;
          fault_d   = 1'b0;
          rf_wr_d   = !is_store_q && (rd_q != 5'd0);
          rf_data_d = ld_val;
          cnt_d     = 32'h0;
        end else if (TIMEOUT > 0 && cnt_q == 32'(TIMEOUT - 1)) begin
          // stb has now been high for TIMEOUT cycles with no ack
          state_d = RESP;
          fault_d = 1'b1;
          cnt_d   = 32'h0;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
        fault_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      is_store_q   <= 1'b0;
      funct3_q     <= 3'b0;
      addr_q       <= 32'h0;
      store_data_q <= 32'h0;
      rd_q         <= 5'd0;
      cnt_q        <= 32'h0;
      fault_q      <= 1'b0;
      rf_wr_q      <= 1'b0;
      rf_data_q    <= 32'h0;
    end else begin
      state_q      <= state_d;
      is_store_q   <= is_store_d;
      funct3_q     <= funct3_d;
      addr_q       <= addr_d;
      store_data_q <= store_data_d;
      rd_q         <= rd_d;
      cnt_q        <= cnt_d;
      fault_q      <= fault_d;
      rf_wr_q      <= rf_wr_d;
      rf_data_q    <= rf_data_d;
    end
  end

  assign in_bus    = (state_q == BUS);
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == RESP);
  assign fault     = done & fault_q;
  assign bus_cyc   = in_bus;
  assign bus_stb   = in_bus;
  assign bus_we    = in_bus & is_store_q;
  assign bus_adr   = in_bus ? {addr_q[31:2], 2'b00} : 32'h0;
  assign bus_sel   = in_bus ? lane_sel : 4'b0000;
  assign bus_dat_o = in_bus ? lane_dat : 32'h0;
  assign rf_wr     = rf_wr_q;
  assign rf_rd     = rd_q;
  assign rf_rd_d   = rf_data_q;

endmodule
